// File: rtl/rbcp_reg_pkg.sv
// Register map constants for the RBCP register responder.
// Offsets are relative to the responder's BASE_ADDR.
package rbcp_reg_pkg;

    localparam logic [31:0] WINDOW_SIZE = 32'd16;

    localparam logic [3:0] OFS_CTRL   = 4'h0;
    localparam logic [3:0] OFS_PULSE  = 4'h1;
    localparam logic [3:0] OFS_USR3   = 4'h2;
    localparam logic [3:0] OFS_USR2   = 4'h3;
    localparam logic [3:0] OFS_USR1   = 4'h4;
    localparam logic [3:0] OFS_USR0   = 4'h5;
    localparam logic [3:0] OFS_STATUS = 4'h6;
    localparam logic [3:0] OFS_ID     = 4'h7;
    localparam logic [3:0] OFS_EVT3   = 4'h8;
    localparam logic [3:0] OFS_EVT2   = 4'h9;
    localparam logic [3:0] OFS_EVT1   = 4'hA;
    localparam logic [3:0] OFS_EVT0   = 4'hB;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_GPIO_BIT = 1;
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_TCP_BIT  = 1;
    localparam int STAT_FIFO_BIT = 2;

    // Big-endian byte select: idx 0 returns bits 31:24, idx 3 returns bits 7:0.
    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/soft_reset_pulser.sv
// Fixed-width SOFT_RESET pulse generator; BUSY is high for exactly the pulse duration.
module soft_reset_pulser
    import rbcp_reg_pkg::*;
#(
    parameter int PULSE_LEN = 16
) (
    input  logic CLK,
    input  logic SYS_RSTn,
    input  logic START,
    output logic BUSY,
    output logic SOFT_RESET
);

    localparam logic [7:0] LEN_C = 8'(PULSE_LEN);

    logic [7:0] cnt_r;
    logic       pulse_r;

    // Down-counter: pulse stays high while the count is about to remain non-zero.
    always_ff @(posedge CLK) begin
        if (!SYS_RSTn) begin
            cnt_r   <= 8'd0;
            pulse_r <= 1'b0;
        end else if (START && (cnt_r == 8'd0)) begin
            cnt_r   <= LEN_C;
            pulse_r <= 1'b1;
        end else if (cnt_r != 8'd0) begin
            cnt_r   <= cnt_r - 8'd1;
            pulse_r <= (cnt_r > 8'd1);
        end else begin
            pulse_r <= 1'b0;
        end
    end

    assign BUSY       = pulse_r;
    assign SOFT_RESET = pulse_r;

endmodule

// File: rtl/rbcp_reg_responder.sv
// SiTCP RBCP slave exposing control, user, status, ID and event-counter registers
// in a 16-byte window at BASE_ADDR.
module rbcp_reg_responder
    import rbcp_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter logic [7:0]  ID_BYTE       = 8'hA5,
    parameter int          RST_PULSE_LEN = 16
) (
    input  logic        CLK,
    input  logic        SYS_RSTn,
    input  logic [31:0] RBCP_ADDR,
    input  logic [7:0]  RBCP_WD,
    input  logic        RBCP_WE,
    input  logic        RBCP_RE,
    output logic        RBCP_ACK,
    output logic [7:0]  RBCP_RD,
    input  logic        TCP_OPEN_ACK,
    input  logic        FIFO_FULL,
    input  logic        EVENT_IN,
    output logic        RUN_EN,
    output logic        GPIO_MODE,
    output logic        SOFT_RESET,
    output logic [31:0] USR_REG
);

    logic [31:0] offs_full_s;
    logic        hit_s;
    logic [3:0]  ofs_s;
    logic        wr_s;
    logic        rd_req_s;
    logic [7:0]  rd_data_s;
    logic        pulse_start_s;
    logic        pulse_busy_s;

    logic        ack_r;
    logic [7:0]  rd_r;
    logic        run_en_r;
    logic        gpio_mode_r;
    logic [31:0] usr_reg_r;
    logic [31:0] evt_cnt_r;
    logic [31:0] snap_r;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap high and miss the window.
    assign offs_full_s   = RBCP_ADDR - BASE_ADDR;
    assign hit_s         = (offs_full_s < WINDOW_SIZE);
    assign ofs_s         = offs_full_s[3:0];
    assign wr_s          = hit_s & RBCP_WE;
    assign rd_req_s      = hit_s & RBCP_RE & ~RBCP_WE;
    assign pulse_start_s = wr_s & (ofs_s == OFS_PULSE) & RBCP_WD[0] & ~pulse_busy_s;

    soft_reset_pulser #(
        .PULSE_LEN (RST_PULSE_LEN)
    ) u_pulser (
        .CLK        (CLK),
        .SYS_RSTn   (SYS_RSTn),
        .START      (pulse_start_s),
        .BUSY       (pulse_busy_s),
        .SOFT_RESET (SOFT_RESET)
    );

    // Read-data multiplexer; 0x08 returns the live count since it is latched this cycle.
    always_comb begin
        rd_data_s = 8'h00;
        case (ofs_s)
            OFS_CTRL: begin
                rd_data_s[CTRL_RUN_BIT]  = run_en_r;
                rd_data_s[CTRL_GPIO_BIT] = gpio_mode_r;
            end
            OFS_PULSE:  rd_data_s = {7'b0, pulse_busy_s};
            OFS_USR3:   rd_data_s = be_byte(usr_reg_r, 2'd0);
            OFS_USR2:   rd_data_s = be_byte(usr_reg_r, 2'd1);
            OFS_USR1:   rd_data_s = be_byte(usr_reg_r, 2'd2);
            OFS_USR0:   rd_data_s = be_byte(usr_reg_r, 2'd3);
            OFS_STATUS: begin
                rd_data_s[STAT_BUSY_BIT] = pulse_busy_s;
                rd_data_s[STAT_TCP_BIT]  = TCP_OPEN_ACK;
                rd_data_s[STAT_FIFO_BIT] = FIFO_FULL;
            end
            OFS_ID:     rd_data_s = ID_BYTE;
            OFS_EVT3:   rd_data_s = be_byte(evt_cnt_r, 2'd0);
            OFS_EVT2:   rd_data_s = be_byte(snap_r, 2'd1);
            OFS_EVT1:   rd_data_s = be_byte(snap_r, 2'd2);
            OFS_EVT0:   rd_data_s = be_byte(snap_r, 2'd3);
            default:    rd_data_s = 8'h00;
        endcase
    end

    // Bus response: one-cycle ACK, read data held until the next accepted access.
    always_ff @(posedge CLK) begin
        if (!SYS_RSTn) begin
            ack_r <= 1'b0;
            rd_r  <= 8'h00;
        end else begin
            ack_r <= wr_s | rd_req_s;
            if (wr_s) begin
                rd_r <= 8'h00;
            end else if (rd_req_s) begin
                rd_r <= rd_data_s;
            end
        end
    end

    // Writable control and user registers.
    always_ff @(posedge CLK) begin
        if (!SYS_RSTn) begin
            run_en_r    <= 1'b0;
            gpio_mode_r <= 1'b0;
            usr_reg_r   <= 32'h0000_0000;
        end else if (wr_s) begin
            case (ofs_s)
                OFS_CTRL: begin
                    run_en_r    <= RBCP_WD[CTRL_RUN_BIT];
                    gpio_mode_r <= RBCP_WD[CTRL_GPIO_BIT];
                end
                OFS_USR3: usr_reg_r[31:24] <= RBCP_WD;
                OFS_USR2: usr_reg_r[23:16] <= RBCP_WD;
                OFS_USR1: usr_reg_r[15:8]  <= RBCP_WD;
                OFS_USR0: usr_reg_r[7:0]   <= RBCP_WD;
                default:  ;
            endcase
        end
    end

    // Event counter with clear-over-increment priority, plus read snapshot.
    always_ff @(posedge CLK) begin
        if (!SYS_RSTn) begin
            evt_cnt_r <= 32'h0000_0000;
            snap_r    <= 32'h0000_0000;
        end else begin
            if (wr_s && (ofs_s == OFS_EVT3)) begin
                evt_cnt_r <= 32'h0000_0000;
            end else if (EVENT_IN) begin
                evt_cnt_r <= evt_cnt_r + 32'd1;
            end
            if (rd_req_s && (ofs_s == OFS_EVT3)) begin
                snap_r <= evt_cnt_r;
            end
        end
    end

    assign RBCP_ACK  = ack_r;
    assign RBCP_RD   = rd_r;
    assign RUN_EN    = run_en_r;
    assign GPIO_MODE = gpio_mode_r;
    assign USR_REG   = usr_reg_r;

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Directed bench for rbcp_reg_responder: vector table for single/back-to-back
// accesses plus hand sequences for the pulser, event counter and reset.
module tb_rbcp_reg_responder;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        CLK;
    logic        SYS_RSTn;
    logic [31:0] RBCP_ADDR;
    logic [7:0]  RBCP_WD;
    logic        RBCP_WE;
    logic        RBCP_RE;
    logic        RBCP_ACK;
    logic [7:0]  RBCP_RD;
    logic        TCP_OPEN_ACK;
    logic        FIFO_FULL;
    logic        EVENT_IN;
    logic        RUN_EN;
    logic        GPIO_MODE;
    logic        SOFT_RESET;
    logic [31:0] USR_REG;

    rbcp_reg_responder #(
        .BASE_ADDR     (BASE),
        .ID_BYTE       (8'hA5),
        .RST_PULSE_LEN (16)
    ) dut (
        .CLK          (CLK),
        .SYS_RSTn     (SYS_RSTn),
        .RBCP_ADDR    (RBCP_ADDR),
        .RBCP_WD      (RBCP_WD),
        .RBCP_WE      (RBCP_WE),
        .RBCP_RE      (RBCP_RE),
        .RBCP_ACK     (RBCP_ACK),
        .RBCP_RD      (RBCP_RD),
        .TCP_OPEN_ACK (TCP_OPEN_ACK),
        .FIFO_FULL    (FIFO_FULL),
        .EVENT_IN     (EVENT_IN),
        .RUN_EN       (RUN_EN),
        .GPIO_MODE    (GPIO_MODE),
        .SOFT_RESET   (SOFT_RESET),
        .USR_REG      (USR_REG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [7:0]  wd;
        logic        tcp;
        logic        fifo;
        logic        exp_ack;
        logic [7:0]  exp_rd;
        logic [1:0]  exp_ctrl;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic we, input logic re, input logic [31:0] addr,
                           input logic [7:0] wd, input logic tcp, input logic fifo,
                           input logic eack, input logic [7:0] erd, input logic [1:0] ectrl);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wd = wd; v.tcp = tcp; v.fifo = fifo;
        v.exp_ack = eack; v.exp_rd = erd; v.exp_ctrl = ectrl;
        vecs.push_back(v);
    endtask

    // One-cycle strobe driven at a negedge; returns at the next negedge with strobes low.
    task automatic strobe(input logic we, input logic re, input logic [31:0] addr, input logic [7:0] wd);
        RBCP_WE   = we;
        RBCP_RE   = re;
        RBCP_ADDR = addr;
        RBCP_WD   = wd;
        @(negedge CLK);
        RBCP_WE = 1'b0;
        RBCP_RE = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] addr, input logic [7:0] exp);
        strobe(1'b0, 1'b1, addr, 8'h00);
        check({nm, " ack"}, {31'b0, RBCP_ACK}, 32'd1);
        check({nm, " rd"}, {24'b0, RBCP_RD}, {24'b0, exp});
    endtask

    initial begin
        int hi;
        int rises;
        int acks;
        logic prev;

        SYS_RSTn = 1'b0; RBCP_ADDR = 32'h0; RBCP_WD = 8'h00; RBCP_WE = 1'b0; RBCP_RE = 1'b0;
        TCP_OPEN_ACK = 1'b0; FIFO_FULL = 1'b0; EVENT_IN = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst ack",  {31'b0, RBCP_ACK},   32'd0);
        check("rst rd",   {24'b0, RBCP_RD},    32'd0);
        check("rst run",  {31'b0, RUN_EN},     32'd0);
        check("rst gpio", {31'b0, GPIO_MODE},  32'd0);
        check("rst soft", {31'b0, SOFT_RESET}, 32'd0);
        check("rst usr",  USR_REG,             32'd0);
        SYS_RSTn = 1'b1;
        @(negedge CLK);

        //      we    re    addr            wd     tcp   fifo  ack   rd     {gpio,run}
        add_vec(1'b1, 1'b0, BASE + 32'h00, 8'h03, 1'b0, 1'b0, 1'b1, 8'h00, 2'b11);
        add_vec(1'b0, 1'b0, BASE + 32'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11);
        add_vec(1'b0, 1'b1, BASE + 32'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h03, 2'b11);
        add_vec(1'b0, 1'b0, BASE + 32'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 2'b11);
        add_vec(1'b1, 1'b0, BASE + 32'h02, 8'h12, 1'b0, 1'b0, 1'b1, 8'h00, 2'b11);
        add_vec(1'b1, 1'b0, BASE + 32'h03, 8'h34, 1'b0, 1'b0, 1'b1, 8'h00, 2'b11);
        add_vec(1'b1, 1'b0, BASE + 32'h04, 8'h56, 1'b0, 1'b0, 1'b1, 8'h00, 2'b11);
        add_vec(1'b1, 1'b0, BASE + 32'h05, 8'h78, 1'b0, 1'b0, 1'b1, 8'h00, 2'b11);
        add_vec(1'b0, 1'b1, BASE + 32'h06, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02, 2'b11);
        add_vec(1'b0, 1'b1, BASE + 32'h07, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 2'b11);
        add_vec(1'b0, 1'b1, BASE + 32'h02, 8'h00, 1'b0, 1'b0, 1'b1, 8'h12, 2'b11);
        add_vec(1'b0, 1'b1, BASE + 32'h05, 8'h00, 1'b0, 1'b0, 1'b1, 8'h78, 2'b11);
        add_vec(1'b0, 1'b1, BASE + 32'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h78, 2'b11);
        add_vec(1'b0, 1'b1, BASE - 32'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h78, 2'b11);
        add_vec(1'b0, 1'b1, BASE + 32'h0D, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'b11);
        add_vec(1'b1, 1'b0, BASE + 32'h07, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'b11);
        add_vec(1'b0, 1'b1, BASE + 32'h07, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 2'b11);
        add_vec(1'b1, 1'b1, BASE + 32'h00, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 2'b01);
        add_vec(1'b0, 1'b0, BASE + 32'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01);
        add_vec(1'b1, 1'b0, BASE + 32'h10, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01);
        add_vec(1'b0, 1'b1, BASE + 32'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 2'b01);
        add_vec(1'b0, 1'b1, BASE + 32'h06, 8'h00, 1'b0, 1'b1, 1'b1, 8'h04, 2'b01);
        add_vec(1'b1, 1'b0, BASE + 32'h06, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 2'b01);
        add_vec(1'b1, 1'b0, BASE + 32'h0F, 8'h03, 1'b0, 1'b0, 1'b1, 8'h00, 2'b01);
        add_vec(1'b0, 1'b1, BASE + 32'h0E, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'b01);
        add_vec(1'b0, 1'b1, BASE + 32'h01, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'b01);

        foreach (vecs[i]) begin
            RBCP_WE = vecs[i].we; RBCP_RE = vecs[i].re; RBCP_ADDR = vecs[i].addr;
            RBCP_WD = vecs[i].wd; TCP_OPEN_ACK = vecs[i].tcp; FIFO_FULL = vecs[i].fifo;
            @(negedge CLK);
            RBCP_WE = 1'b0; RBCP_RE = 1'b0; TCP_OPEN_ACK = 1'b0; FIFO_FULL = 1'b0;
            check($sformatf("vec%0d ack", i), {31'b0, RBCP_ACK}, {31'b0, vecs[i].exp_ack});
            check($sformatf("vec%0d rd", i), {24'b0, RBCP_RD}, {24'b0, vecs[i].exp_rd});
            check($sformatf("vec%0d ctrl", i), {30'b0, GPIO_MODE, RUN_EN}, {30'b0, vecs[i].exp_ctrl});
        end
        check("usr_reg", USR_REG, 32'h1234_5678);

        // Soft-reset pulse with a retrigger attempt while busy.
        strobe(1'b1, 1'b0, BASE + 32'h01, 8'h01);
        check("pulse wr ack", {31'b0, RBCP_ACK}, 32'd1);
        hi = 0; rises = 0; prev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (SOFT_RESET) hi++;
            if (SOFT_RESET && !prev) rises++;
            prev = SOFT_RESET;
            if (k == 6) begin
                check("retrig ack", {31'b0, RBCP_ACK}, 32'd1);
                check("retrig rd", {24'b0, RBCP_RD}, 32'd0);
            end
            if (k == 9) begin
                check("busy ack", {31'b0, RBCP_ACK}, 32'd1);
                check("busy rd", {24'b0, RBCP_RD}, 32'h01);
            end
            RBCP_WE = (k == 5); RBCP_RE = (k == 8);
            RBCP_ADDR = BASE + 32'h01; RBCP_WD = 8'h01;
            @(negedge CLK);
        end
        RBCP_WE = 1'b0; RBCP_RE = 1'b0;
        check("pulse width", hi, 32'd16);
        check("pulse count", rises, 32'd1);
        rd_chk("idle pulse", BASE + 32'h01, 8'h00);

        // Event counter: 300 events, then snapshot reads while events continue.
        EVENT_IN = 1'b1;
        repeat (300) @(negedge CLK);
        EVENT_IN = 1'b0;
        rd_chk("cnt300 b3", BASE + 32'h08, 8'h00);
        EVENT_IN = 1'b1;
        rd_chk("cnt300 b2", BASE + 32'h09, 8'h00);
        rd_chk("cnt300 b1", BASE + 32'h0A, 8'h01);
        rd_chk("cnt300 b0", BASE + 32'h0B, 8'h2C);
        EVENT_IN = 1'b0;

        // Wrap: start the count near the top, then three real events.
        force dut.evt_cnt_r = 32'hFFFF_FFFE;
        @(negedge CLK);
        release dut.evt_cnt_r;
        EVENT_IN = 1'b1;
        repeat (3) @(negedge CLK);
        EVENT_IN = 1'b0;
        rd_chk("wrap b3", BASE + 32'h08, 8'h00);
        rd_chk("wrap b2", BASE + 32'h09, 8'h00);
        rd_chk("wrap b1", BASE + 32'h0A, 8'h00);
        rd_chk("wrap b0", BASE + 32'h0B, 8'h01);

        // Clear coincident with an event: clear must win.
        EVENT_IN = 1'b1;
        strobe(1'b1, 1'b0, BASE + 32'h08, 8'h5A);
        EVENT_IN = 1'b0;
        check("clr ack", {31'b0, RBCP_ACK}, 32'd1);
        rd_chk("clr b3", BASE + 32'h08, 8'h00);
        rd_chk("clr b0", BASE + 32'h0B, 8'h00);

        // Reset during pulse cycle 4, with a coincident strobe.
        strobe(1'b1, 1'b0, BASE + 32'h01, 8'h01);
        @(negedge CLK);
        strobe(1'b0, 1'b1, BASE + 32'h02, 8'h00);
        check("mid rd", {24'b0, RBCP_RD}, 32'h12);
        @(negedge CLK);
        check("mid soft", {31'b0, SOFT_RESET}, 32'd1);
        SYS_RSTn = 1'b0; RBCP_RE = 1'b1; RBCP_ADDR = BASE + 32'h07;
        @(negedge CLK);
        check("rst2 soft", {31'b0, SOFT_RESET}, 32'd0);
        check("rst2 ack",  {31'b0, RBCP_ACK},   32'd0);
        check("rst2 rd",   {24'b0, RBCP_RD},    32'd0);
        check("rst2 ctrl", {30'b0, GPIO_MODE, RUN_EN}, 32'd0);
        check("rst2 usr",  USR_REG,             32'd0);
        @(negedge CLK);
        SYS_RSTn = 1'b1; RBCP_RE = 1'b0;
        hi = 0; acks = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (SOFT_RESET) hi++;
            if (RBCP_ACK) acks++;
        end
        check("post-rst pulse", hi, 32'd0);
        check("post-rst acks", acks, 32'd0);
        rd_chk("post-rst ctrl", BASE + 32'h00, 8'h00);
        rd_chk("post-rst busy", BASE + 32'h01, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
